// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters and a registered 1-cycle lookup
module branch_predictor #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_req,
    input  logic [31:0] pred_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);
    localparam int N = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;
    logic             valid_q  [N];
    logic [TAG_W-1:0] tag_q    [N];
    logic [31:0]      target_q [N];
    logic [1:0]       ctr_q    [N];
    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, l_take, u_hit;
    logic [1:0]       u_ctr, ctr_nxt;
    logic             unused_pc_bits;
    assign l_idx = pred_pc[IDX_W+1:2];
    assign l_tag = pred_pc[31:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];
    assign unused_pc_bits = ^{pred_pc[1:0], upd_pc[1:0]};
    assign l_hit = valid_q[l_idx] && tag_q[l_idx] == l_tag;
    assign l_take = l_hit && ctr_q[l_idx][1];
    assign u_hit = valid_q[u_idx] && tag_q[u_idx] == u_tag;
    assign u_ctr = ctr_q[u_idx];
    assign ctr_nxt = upd_taken ? (u_ctr == 2'b11 ? 2'b11 : u_ctr + 2'd1)
                               : (u_ctr == 2'b00 ? 2'b00 : u_ctr - 2'd1);
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= 32'h0;
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else begin
            pred_valid <= pred_req;
            if (pred_req) begin
                pred_taken  <= l_take;
                pred_target <= l_take ? target_q[l_idx] : pred_pc + 32'd4;
            end
            if (upd_valid && u_hit) begin
                ctr_q[u_idx] <= ctr_nxt;
            end else if (upd_valid && upd_taken) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= 2'b10;
            end
        end
    end
    // Tag and target need no reset; a taken update either refreshes a hit or allocates.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= upd_target;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table plus hand sequences for branch_predictor
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pred_req = 1'b0;
    logic [31:0] pred_pc = 32'h0;
    logic        pred_valid, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'h0;
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        logic        r;
        logic        req;
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        chk;
        logic        ev;
        logic        et;
        logic [31:0] etgt;
    } vec_t;
    vec_t vecs[$];

    branch_predictor #(.IDX_W(4)) dut (
        .clk(clk), .rst(rst),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", nm, i, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int i);
        rst        = t.r;
        pred_req   = t.req;
        pred_pc    = t.pc;
        upd_valid  = t.uv;
        upd_pc     = t.upc;
        upd_taken  = t.ut;
        upd_target = t.utgt;
        @(posedge clk);
        #1;
        cmp("pred_valid", i, {31'b0, pred_valid}, {31'b0, t.ev});
        if (t.chk) begin
            cmp("pred_taken", i, {31'b0, pred_taken}, {31'b0, t.et});
            cmp("pred_target", i, pred_target, t.etgt);
        end
    endtask

    task automatic add(input logic r, input logic req, input logic [31:0] pc,
                       input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input logic chk, input logic ev, input logic et, input logic [31:0] etgt);
        vec_t t;
        t.r = r; t.req = req; t.pc = pc;
        t.uv = uv; t.upc = upc; t.ut = ut; t.utgt = utgt;
        t.chk = chk; t.ev = ev; t.et = et; t.etgt = etgt;
        vecs.push_back(t);
    endtask

    initial begin
        //   rst req pc            uv upc           ut utgt          chk ev et etgt
        add(1, 1, 32'h0000_0100, 1, 32'h0000_0100, 1, 32'h0000_0080, 1, 0, 0, 32'h0);
        add(0, 1, 32'h0000_0100, 0, 32'h0,         0, 32'h0,         1, 1, 0, 32'h0000_0104);
        add(0, 1, 32'h0000_0100, 1, 32'h0000_0100, 1, 32'h0000_0080, 1, 1, 0, 32'h0000_0104);
        add(0, 1, 32'h0000_0100, 0, 32'h0,         0, 32'h0,         1, 1, 1, 32'h0000_0080);
        add(0, 0, 32'h0,         1, 32'h0000_0100, 1, 32'h0000_0080, 0, 0, 0, 32'h0);
        add(0, 0, 32'h0,         1, 32'h0000_0100, 1, 32'h0000_0080, 0, 0, 0, 32'h0);
        add(0, 0, 32'h0,         1, 32'h0000_0100, 1, 32'h0000_0080, 0, 0, 0, 32'h0);
        add(0, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0,         0, 0, 0, 32'h0);
        add(0, 1, 32'h0000_0100, 0, 32'h0,         0, 32'h0,         1, 1, 1, 32'h0000_0080);
        add(0, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0,         0, 0, 0, 32'h0);
        add(0, 1, 32'h0000_0100, 0, 32'h0,         0, 32'h0,         1, 1, 0, 32'h0000_0104);
        add(0, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0,         0, 0, 0, 32'h0);
        add(0, 0, 32'h0,         1, 32'h0000_0100, 0, 32'h0,         0, 0, 0, 32'h0);
        add(0, 0, 32'h0,         1, 32'h0000_0100, 1, 32'h0000_0080, 0, 0, 0, 32'h0);
        add(0, 1, 32'h0000_0100, 0, 32'h0,         0, 32'h0,         1, 1, 0, 32'h0000_0104);
        add(0, 0, 32'h0,         1, 32'h0000_0100, 1, 32'h0000_0200, 0, 0, 0, 32'h0);
        add(0, 1, 32'h0000_0100, 0, 32'h0,         0, 32'h0,         1, 1, 1, 32'h0000_0200);
        add(0, 0, 32'h0,         1, 32'h0000_0140, 1, 32'h0000_0300, 0, 0, 0, 32'h0);
        add(0, 1, 32'h0000_0100, 0, 32'h0,         0, 32'h0,         1, 1, 0, 32'h0000_0104);
        add(0, 1, 32'h0000_0140, 0, 32'h0,         0, 32'h0,         1, 1, 1, 32'h0000_0300);
        add(0, 0, 32'h0,         1, 32'h0000_0180, 0, 32'h0,         0, 0, 0, 32'h0);
        add(0, 1, 32'h0000_0140, 0, 32'h0,         0, 32'h0,         1, 1, 1, 32'h0000_0300);
        add(0, 1, 32'hFFFF_FFFC, 0, 32'h0,         0, 32'h0,         1, 1, 0, 32'h0000_0000);
        add(0, 0, 32'h0000_0140, 0, 32'h0,         0, 32'h0,         1, 0, 0, 32'h0000_0000);
        add(0, 0, 32'h0,         1, 32'h0000_1004, 1, 32'h0000_0040, 0, 0, 0, 32'h0);
        add(0, 1, 32'h0000_1006, 0, 32'h0,         0, 32'h0,         1, 1, 1, 32'h0000_0040);
        add(1, 1, 32'h0000_0140, 1, 32'h0000_2008, 1, 32'h0000_099C, 1, 0, 0, 32'h0);
        add(0, 1, 32'h0000_0140, 0, 32'h0,         0, 32'h0,         1, 1, 0, 32'h0000_0144);
        add(0, 1, 32'h0000_1004, 0, 32'h0,         0, 32'h0,         1, 1, 0, 32'h0000_1008);
        add(0, 1, 32'h0000_2008, 0, 32'h0,         0, 32'h0,         1, 1, 0, 32'h0000_200C);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Read-before-write on a hit: the not-taken update lands after the taken lookup
        apply(vec_t'{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0}, 100);
        apply(vec_t'{1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 32'h0}, 101);
        apply(vec_t'{1'b0, 1'b1, 32'h0000_0300, 1'b1, 32'h0000_0300, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_0500}, 102);
        apply(vec_t'{1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0000_0304}, 103);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
